// File: rtl/count_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter for the 8-digit display driver.
// Each conversion takes one bit per clock, then applies leading-zero blanking or a dash overflow pattern.
module count_bcd_display #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8,
    parameter int BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  out_valid
);
    // state   | meaning
    // S_IDLE  | waiting for a request, in_ready high
    // S_SHIFT | one double-dabble step per cycle
    // S_DONE  | result is on bcd/ovf with out_valid high
    localparam int IDIG = (WIDTH * 77) / 256 + 1;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      sreg;
    logic [4*IDIG-1:0]     acc, acc_adj, acc_nxt;
    logic [CW-1:0]         cnt;
    logic                  last_shift;
    logic [4*DIGITS-1:0]   bcd_nxt;
    logic                  ovf_nxt;
    logic                  seen_nz;

    // +3 correction is confined to each digit; no carries between digits
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < IDIG; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = 4'(acc[4*i +: 4] + 4'd3);
        end
        acc_nxt = {acc_adj[4*IDIG-2:0], sreg[WIDTH-1]};
    end

    // Result formatting works on the post-shift accumulator so bcd lands together with out_valid
    always_comb begin
        ovf_nxt = 1'b0;
        for (int i = DIGITS; i < IDIG; i++) begin
            if (acc_nxt[4*i +: 4] != 4'd0)
                ovf_nxt = 1'b1;
        end
        bcd_nxt = acc_nxt[4*DIGITS-1:0];
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (acc_nxt[4*i +: 4] != 4'd0)
                seen_nz = 1'b1;
            else if (!seen_nz && (BLANK != 0))
                bcd_nxt[4*i +: 4] = 4'hF;
        end
        if (ovf_nxt)
            bcd_nxt = {DIGITS{4'hA}};
    end

    assign last_shift = (state == S_SHIFT) && (cnt == CW'(1));
    assign in_ready   = (state == S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            bcd       <= (BLANK != 0) ? {DIGITS{4'hF}} : '0;
        end else begin
            state     <= state_nxt;
            out_valid <= last_shift;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sreg <= in_value;
                        acc  <= '0;
                        cnt  <= CW'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    acc  <= acc_nxt;
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - CW'(1);
                    if (last_shift) begin
                        bcd <= bcd_nxt;
                        ovf <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
